// File: rtl/sync_capture_mc.sv
// Multi-channel capture of foreign-domain data words qualified by asynchronous enables.
// Each enable is synchronised; the data bus is sampled only while its enable is known stable.
module sync_capture_mc #(
  parameter int DW     = 32'sd4,
  parameter int NCH    = 32'sd2,
  parameter int STAGES = 32'sd2,
  parameter int MODE   = 32'sd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    in_en,
  output logic [NCH*DW-1:0] out_data,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [NCH-1:0]    ack,
  output logic [NCH-1:0]    overrun,
  input  logic [NCH-1:0]    ovr_clr
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam bit LEVEL_MODE = (MODE == 32'sd0);

  if (STAGES < 32'sd2) begin : g_bad_stages
    $error("sync_capture_mc: STAGES must be at least 2");
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [STAGES-1:0] r_sync;
    logic              r_en_d;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [DW-1:0]     r_data;
    logic [DW-1:0]     w_data_nxt;
    logic              r_ovr;
    logic              w_ovr_nxt;
    logic              w_ovr_set;
    logic              w_en_s;
    logic              w_ev;

    assign w_en_s = r_sync[STAGES-1];
    assign w_ev   = LEVEL_MODE ? w_en_s : (w_en_s & ~r_en_d);

    // enable synchroniser chain plus one extra flop for edge detection
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sync <= '0;
        r_en_d <= 1'b0;
      end else begin
        r_sync <= {r_sync[STAGES-2:0], in_en[k]};
        r_en_d <= w_en_s;
      end
    end

    // holding-register state, data and sticky overrun
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= ST_EMPTY;
        r_data  <= '0;
        r_ovr   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_data  <= w_data_nxt;
        r_ovr   <= w_ovr_nxt;
      end
    end

    // next state: a capture lands if the slot is empty or being drained this cycle
    always_comb begin
      w_state_nxt = r_state;
      w_data_nxt  = r_data;
      w_ovr_set   = 1'b0;
      case (r_state)
        ST_EMPTY: begin
          if (w_ev) begin
            w_state_nxt = ST_FULL;
            w_data_nxt  = in_data[k*DW +: DW];
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready[k]) begin
            if (w_ev) begin
              w_data_nxt = in_data[k*DW +: DW];
            end else begin
              w_state_nxt = ST_EMPTY;
            end
          end else begin
            if (w_ev) begin
              w_ovr_set = 1'b1;
            end else begin
              w_ovr_set = 1'b0;
            end
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
      // a lost word in the same cycle as a clear must stay visible
      w_ovr_nxt = w_ovr_set | (r_ovr & ~ovr_clr[k]);
    end

    assign out_data[k*DW +: DW] = r_data;
    assign out_valid[k]         = (r_state == ST_FULL);
    assign ack[k]               = w_en_s;
    assign overrun[k]           = r_ovr;
  end

endmodule

// File: tb/tb_sync_capture_mc.sv
// Randomised and directed bench for sync_capture_mc: an edge-mode and a level-mode
// instance share stimulus and are checked every cycle against a behavioural model.
module tb_sync_capture_mc;
  localparam int DW     = 4;
  localparam int NCH    = 2;
  localparam int STAGES = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_en;
  logic [NCH-1:0]    out_ready;
  logic [NCH-1:0]    ovr_clr;

  logic [NCH*DW-1:0] e_data, l_data;
  logic [NCH-1:0]    e_valid, e_ack, e_ovr;
  logic [NCH-1:0]    l_valid, l_ack, l_ovr;

  int n_vec = 0;
  int n_err = 0;

  // model: per-channel history of sampled enables (bit 0 = newest sample)
  logic [31:0]   hist    [NCH];
  // model holding slots, index 0 = level instance, 1 = edge instance
  logic          m_valid [2][NCH];
  logic [DW-1:0] m_data  [2][NCH];
  logic          m_ovr   [2][NCH];

  always #5 clk = ~clk;

  sync_capture_mc #(.DW(DW), .NCH(NCH), .STAGES(STAGES), .MODE(1)) u_edge (
    .clk(clk), .rst(rst), .in_data(in_data), .in_en(in_en),
    .out_data(e_data), .out_valid(e_valid), .out_ready(out_ready),
    .ack(e_ack), .overrun(e_ovr), .ovr_clr(ovr_clr)
  );

  sync_capture_mc #(.DW(DW), .NCH(NCH), .STAGES(STAGES), .MODE(0)) u_level (
    .clk(clk), .rst(rst), .in_data(in_data), .in_en(in_en),
    .out_data(l_data), .out_valid(l_valid), .out_ready(out_ready),
    .ack(l_ack), .overrun(l_ovr), .ovr_clr(ovr_clr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // advance the model by one clock edge using the inputs the DUT sees at that edge
  task automatic model_step();
    for (int k = 0; k < NCH; k++) begin
      logic s, d, ev, took;
      s = hist[k][STAGES-1];
      d = hist[k][STAGES];
      for (int m = 0; m < 2; m++) begin
        ev = (m == 0) ? s : (s & ~d);
        if (rst) begin
          m_valid[m][k] = 1'b0;
          m_data[m][k]  = '0;
          m_ovr[m][k]   = 1'b0;
        end else begin
          took = m_valid[m][k] & out_ready[k];
          if (ev && m_valid[m][k] && !took) m_ovr[m][k] = 1'b1;
          else if (ovr_clr[k]) m_ovr[m][k] = 1'b0;
          if (ev && (!m_valid[m][k] || took)) begin
            m_data[m][k]  = in_data[k*DW +: DW];
            m_valid[m][k] = 1'b1;
          end else if (took) begin
            m_valid[m][k] = 1'b0;
          end
        end
      end
      hist[k] = rst ? 32'd0 : {hist[k][30:0], in_en[k]};
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      logic [NCH*DW-1:0] ed, ad;
      logic [NCH-1:0]    evl, av, ea, aa, eo, ao;
      for (int k = 0; k < NCH; k++) begin
        ed[k*DW +: DW] = m_data[m][k];
        evl[k]         = m_valid[m][k];
        ea[k]          = hist[k][STAGES-1];
        eo[k]          = m_ovr[m][k];
      end
      ad = (m == 1) ? e_data  : l_data;
      av = (m == 1) ? e_valid : l_valid;
      aa = (m == 1) ? e_ack   : l_ack;
      ao = (m == 1) ? e_ovr   : l_ovr;
      n_vec++;
      if ({ad, av, aa, ao} !== {ed, evl, ea, eo}) begin
        n_err++;
        $display("FAIL model_cmp inst=%0d t=%0t got data=%h valid=%b ack=%b ovr=%b want data=%h valid=%b ack=%b ovr=%b",
                 m, $time, ad, av, aa, ao, ed, evl, ea, eo);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    int cnt;
    rst = 1'b1; in_en = '0; in_data = '0; out_ready = '0; ovr_clr = '0;
    for (int k = 0; k < NCH; k++) hist[k] = 32'd0;
    tick(); tick();
    chk("reset_outputs", 32'({e_data, e_valid, e_ack, e_ovr}), 32'd0);

    // single edge capture with latency check, enable held 20 cycles
    rst = 1'b0; in_data = 8'h0A; in_en = 2'b01; out_ready = 2'b11;
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) chk("ack_edge1", 32'(e_ack[0]), 32'd0);
      if (i == 2) begin
        chk("ack_edge2", 32'(e_ack[0]), 32'd1);
        chk("valid_edge2", 32'(e_valid[0]), 32'd0);
      end
      if (i == 3) begin
        chk("valid_edge3", 32'(e_valid[0]), 32'd1);
        chk("data_edge3", 32'(e_data[3:0]), 32'hA);
      end
      if (i == 4) chk("valid_edge4", 32'(e_valid[0]), 32'd0);
      cnt += int'(e_valid[0]);
    end
    chk("hold_one_capture", 32'(cnt), 32'd1);
    chk("hold_no_overrun", 32'(e_ovr[0]), 32'd0);
    in_en = 2'b00;
    repeat (4) tick();

    // overrun with consumer stalled
    out_ready = 2'b10; in_data = 8'h03; in_en = 2'b01;
    repeat (2) tick();
    in_en = 2'b00;
    repeat (3) tick();
    in_data = 8'h05; in_en = 2'b01;
    repeat (2) tick();
    in_en = 2'b00;
    repeat (4) tick();
    chk("ovr_keep_data", 32'(e_data[3:0]), 32'h3);
    chk("ovr_valid", 32'(e_valid[0]), 32'd1);
    chk("ovr_set", 32'(e_ovr[0]), 32'd1);
    ovr_clr = 2'b01;
    tick();
    ovr_clr = 2'b00;
    chk("ovr_clear", 32'(e_ovr[0]), 32'd0);
    out_ready = 2'b11;
    tick();
    chk("drain_after_ovr", 32'(e_valid[0]), 32'd0);

    // both channels at once
    in_data = 8'h91; in_en = 2'b11;
    repeat (3) tick();
    chk("dual_valid", 32'(e_valid), 32'h3);
    chk("dual_data", 32'(e_data), 32'h91);
    in_en = 2'b00;
    repeat (5) tick();

    // reset while holding a word, enable stays high through release
    out_ready = 2'b00; in_data = 8'h07; in_en = 2'b01;
    repeat (3) tick();
    chk("pre_rst_valid", 32'(e_valid[0]), 32'd1);
    chk("pre_rst_data", 32'(e_data[3:0]), 32'h7);
    rst = 1'b1;
    tick();
    chk("rst_clears", 32'({e_data, e_valid, e_ack, e_ovr}), 32'd0);
    rst = 1'b0;
    repeat (2) tick();
    chk("post_rst_edge2", 32'(e_valid[0]), 32'd0);
    tick();
    chk("post_rst_edge3_valid", 32'(e_valid[0]), 32'd1);
    chk("post_rst_edge3_data", 32'(e_data[3:0]), 32'h7);
    chk("post_rst_no_ovr", 32'(e_ovr), 32'd0);
    in_en = 2'b00; out_ready = 2'b11; ovr_clr = 2'b11;
    tick();
    ovr_clr = 2'b00;
    repeat (4) tick();

    // level mode: four enable cycles give four consecutive words
    cnt = 0;
    in_en = 2'b10;
    for (int i = 0; i < 4; i++) begin
      in_data = {4'(i + 2), 4'h0};
      tick();
      cnt += int'(l_valid[1]);
    end
    in_en = 2'b00;
    for (int i = 0; i < 6; i++) begin
      tick();
      cnt += int'(l_valid[1]);
    end
    chk("level_word_count", 32'(cnt), 32'd4);
    chk("level_no_ovr", 32'(l_ovr[1]), 32'd0);

    // randomised traffic
    for (int i = 0; i < 800; i++) begin
      in_data = 8'($urandom);
      for (int k = 0; k < NCH; k++)
        if ($urandom_range(0, 3) == 0) in_en[k] = ~in_en[k];
      out_ready = 2'($urandom);
      ovr_clr   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      rst       = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sync_capture_mc.md
SYNC_CAPTURE_MC -- requirements
Module: sync_capture_mc

Interface
REQ-001 Parameter DW, default 4, data width per channel in bits (>=1).
REQ-002 Parameter NCH, default 2, number of independent channels (>=1).
REQ-003 Parameter STAGES, default 2, synchroniser flop count on each enable (>=2); any other value SHALL fail elaboration.
REQ-004 Parameter MODE, default 1: 0 = level capture (every cycle enable is high), 1 = edge capture (once per enable rising edge).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 in_data  input  NCH*DW  foreign-domain data; channel k occupies bits [k*DW +: DW]; sender holds it stable while in_en[k] is high.
REQ-008 in_en  input  NCH  foreign-domain qualifier per channel, asynchronous to clk.
REQ-009 out_data  output  NCH*DW  captured data per channel, same packing as in_data.
REQ-010 out_valid  output  NCH  channel k holds a word not yet consumed.
REQ-011 out_ready  input  NCH  consumer accepts channel k word when out_valid[k] & out_ready[k].
REQ-012 ack  output  NCH  synchronised in_en (last sync stage), returned to sender for 4-phase handshake.
REQ-013 overrun  output  NCH  sticky flag: capture event lost on channel k.
REQ-014 ovr_clr  input  NCH  one-cycle clear of overrun[k].

Function
REQ-015 Each in_en[k] SHALL pass through STAGES flops; en_s[k] = last stage; en_d[k] = en_s[k] delayed one more flop; in_data SHALL NOT be synchronised.
REQ-016 Capture event ev[k]: MODE 0 -> en_s[k]; MODE 1 -> en_s[k] & ~en_d[k].
REQ-017 Per-channel state: EMPTY (out_valid=0) or FULL (out_valid=1).
REQ-018 EMPTY & ev -> load out_data from in_data, go FULL.
REQ-019 FULL & out_ready & ev -> load new word, stay FULL (back-to-back, no bubble).
REQ-020 FULL & out_ready & ~ev -> go EMPTY; out_data keeps last value.
REQ-021 FULL & ~out_ready & ev -> keep old word, set overrun[k]; new word dropped.
REQ-022 FULL & ~out_ready & ~ev -> hold.
REQ-023 overrun[k] SHALL clear on ovr_clr[k]; if set and clear occur in the same cycle, set wins.
REQ-024 Latency: in_en[k] rise sampled at edge 1 -> en_s[k] high after edge STAGES -> out_valid[k] high after edge STAGES+1.
REQ-025 ack[k] SHALL equal en_s[k]; it falls STAGES edges after in_en[k] falls.
REQ-026 Channels SHALL be fully independent; no cross-channel priority or shared state.
REQ-027 MODE 1: enable held high SHALL produce exactly one capture; a new capture requires in_en low for at least one sampled cycle.
REQ-028 MODE 0: consumer holding out_ready=1 receives one word per cycle while en_s[k]=1; out_ready=0 with en_s[k]=1 sets overrun every such cycle.

Reset
REQ-029 rst=1 at an edge SHALL clear all sync flops, en_d, out_data, out_valid, ack and overrun to 0, overriding all other inputs.
REQ-030 Reset mid-operation SHALL discard held words and pending events without raising overrun.
REQ-031 MODE 1: in_en[k] already high when rst deasserts SHALL yield one capture at edge STAGES+1 after release.

Verification (DW=4, NCH=2, STAGES=2, MODE=1 unless stated)
REQ-032 in_data[3:0]=4'hA, in_en[0] 0->1 before edge 1, out_ready=1 -> out_valid[0]=1, out_data[3:0]=4'hA after edge 3, low after edge 4; ack[0]=1 after edge 2.
REQ-033 in_en[0] held high 20 cycles -> exactly one out_valid[0] pulse, overrun[0]=0.
REQ-034 out_ready[0]=0, two pulses 4'h3 then 4'h5 -> out_data[3:0] stays 4'h3, overrun[0]=1; ovr_clr[0] pulse -> overrun[0]=0.
REQ-035 Channel 0 word 4'h1 and channel 1 word 4'h9 on the same cycle -> both valid after edge 3 with correct data, no interaction.
REQ-036 rst pulsed while out_valid[0]=1 -> all outputs 0 next edge; with in_en[0] still high -> one new capture at edge 3 after release.
REQ-037 MODE=0, in_en[1] high 4 cycles, out_ready[1]=1 -> 4 consecutive valid words, overrun[1]=0.
